// File: rtl/count_uart_pkg.sv
// Shared definitions for the counter UART transmitter: FSM states,
// frame constants and the FIFO level-width helper.
package count_uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  // Occupancy runs 0..depth inclusive, so it needs one bit more than a pointer.
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/count_uart_tx_byte_fifo.sv
// Small synchronous byte FIFO with push/pop and an explicit occupancy count.
// Pointers wrap naturally because the depth is a power of two.
module byte_fifo
  import count_uart_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LVL_W = level_width(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push_i,
  input  logic [UART_DATA_BITS-1:0] wr_data_i,
  input  logic                      pop_i,
  output logic [UART_DATA_BITS-1:0] rd_data_o,
  output logic [LVL_W-1:0]          level_o,
  output logic                      full_o,
  output logic                      empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [UART_DATA_BITS-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]          wr_ptr_q;
  logic [PTR_W-1:0]          rd_ptr_q;
  logic [LVL_W-1:0]          level_q;
  logic                      push_ok;
  logic                      pop_ok;

  assign full_o    = (level_q == LVL_W'(DEPTH));
  assign empty_o   = (level_q == '0);
  assign push_ok   = push_i && !full_o;
  assign pop_ok    = pop_i && !empty_o;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign level_o   = level_q;

  // Storage array; holds data only, so it carries no reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  // Pointers and occupancy; a simultaneous push and pop leaves the level unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/count_uart_tx.sv
// 8N1 UART transmitter fed by a valid/ready byte FIFO. The FSM pops the
// FIFO head into a shift register and serializes it LSB first; frames
// run back to back with no idle bit while the FIFO has data.
module count_uart_tx
  import count_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [UART_DATA_BITS-1:0]            in_data,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  output logic                                 txd,
  output logic                                 busy,
  output logic [level_width(FIFO_DEPTH)-1:0]   fifo_level
);

  localparam int LVL_W  = level_width(FIFO_DEPTH);
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        BIT_LAST  = 3'(UART_DATA_BITS - 1);

  uart_state_e               state_q;
  logic [BAUD_W-1:0]         baud_q;
  logic [2:0]                bit_q;
  logic [UART_DATA_BITS-1:0] shift_q;
  logic                      txd_q;
  logic                      busy_q;

  logic                      push_w;
  logic                      pop_w;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [UART_DATA_BITS-1:0] head_data;
  logic                      baud_last;
  logic                      stay_idle;
  logic [LVL_W-1:0]          level_d;

  // Acceptance uses the registered level, so a full FIFO refuses even on a pop cycle.
  assign in_ready  = !fifo_full;
  assign push_w    = in_valid && in_ready;
  assign baud_last = (baud_q == BAUD_LAST);
  // The FSM takes a byte when idle, or on the final stop cycle to chain frames.
  assign pop_w     = !fifo_empty &&
                     ((state_q == IDLE) || ((state_q == STOP) && baud_last));
  // FSM will be in IDLE after this edge.
  assign stay_idle = !pop_w &&
                     ((state_q == IDLE) || ((state_q == STOP) && baud_last));
  assign txd       = txd_q;
  assign busy      = busy_q;

  byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (push_w),
    .wr_data_i (in_data),
    .pop_i     (pop_w),
    .rd_data_o (head_data),
    .level_o   (fifo_level),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // Post-edge FIFO occupancy, needed so busy is registered in step with the level.
  always_comb begin
    level_d = fifo_level;
    if (push_w && !pop_w) begin
      level_d = fifo_level + LVL_W'(1);
    end else if (pop_w && !push_w) begin
      level_d = fifo_level - LVL_W'(1);
    end
  end

  // Transmit FSM with baud counter, bit counter, shift register and registered line outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      busy_q <= stay_idle ? (level_d != '0) : 1'b1;
      case (state_q)
        IDLE: begin
          txd_q  <= 1'b1;
          baud_q <= '0;
          if (pop_w) begin
            shift_q <= head_data;
            txd_q   <= 1'b0;
            state_q <= START;
          end
        end
        START: begin
          if (baud_last) begin
            baud_q  <= '0;
            bit_q   <= '0;
            txd_q   <= shift_q[0];
            state_q <= DATA;
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        DATA: begin
          if (baud_last) begin
            baud_q <= '0;
            if (bit_q == BIT_LAST) begin
              txd_q   <= 1'b1;
              state_q <= STOP;
            end else begin
              shift_q <= {1'b0, shift_q[UART_DATA_BITS-1:1]};
              txd_q   <= shift_q[1];
              bit_q   <= bit_q + 3'd1;
            end
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        STOP: begin
          if (baud_last) begin
            baud_q <= '0;
            if (pop_w) begin
              shift_q <= head_data;
              txd_q   <= 1'b0;
              state_q <= START;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          txd_q   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_count_uart_tx.sv
// Bench for count_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4. A frame-level
// reference (byte queue plus frame start time) predicts txd, busy, level and
// in_ready after every rising edge.
module tb_count_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       txd;
  logic       busy;
  logic [2:0] fifo_level;

  int checks = 0;
  int failures = 0;

  // Reference state
  logic [7:0] mq[$];
  logic [7:0] cur;
  bit         active = 0;
  int         fstart = 0;
  int         t = 0;
  bit         last_acc = 0;
  logic [7:0] src[$];

  count_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .txd        (txd),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
    end
  endtask

  function automatic logic exp_txd();
    int k;
    if (!active) return 1'b1;
    k = (t - fstart) / CPB;
    if (k == 0) return 1'b0;
    if (k <= 8) return cur[k-1];
    return 1'b1;
  endfunction

  // Advance the reference across edge t using the inputs presented to that edge.
  task automatic model_edge();
    bit acc;
    acc = in_valid && (mq.size() < DEPTH);
    if (active && (t == fstart + FRAME)) active = 0;
    if (!active && (mq.size() > 0)) begin
      cur = mq.pop_front();
      fstart = t;
      active = 1;
    end
    if (acc) mq.push_back(in_data);
    last_acc = acc;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("txd", {31'd0, txd}, {31'd0, exp_txd()});
    check("busy", {31'd0, busy}, {31'd0, (active || (mq.size() > 0))});
    check("level", {29'd0, fifo_level}, mq.size());
    check("in_ready", {31'd0, in_ready}, {31'd0, (mq.size() < DEPTH)});
    t++;
  endtask

  // Present bytes from src with valid/ready handshaking for n edges.
  task automatic run(input int n);
    repeat (n) begin
      if (src.size() > 0) begin
        in_valid = 1'b1;
        in_data  = src[0];
      end else begin
        in_valid = 1'b0;
        in_data  = 'x;
      end
      step();
      if (last_acc) void'(src.pop_front());
    end
    in_valid = 1'b0;
  endtask

  task automatic run_until(input int when);
    while (t < when) run(1);
  endtask

  task automatic push_now(input logic [7:0] b);
    src.push_back(b);
    run(1);
  endtask

  // Assert reset between edges and check the asynchronous effect before any edge.
  task automatic do_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    check({tag, "_txd"}, {31'd0, txd}, 32'd1);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_level"}, {29'd0, fifo_level}, 32'd0);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    mq.delete();
    src.delete();
    active = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int n0;
    int guard;

    // Power-on reset
    #1 rst_n = 1'b0;
    #1;
    check("por_txd", {31'd0, txd}, 32'd1);
    check("por_busy", {31'd0, busy}, 32'd0);
    check("por_level", {29'd0, fifo_level}, 32'd0);
    check("por_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run(100);

    // Single byte 0xA5, busy falls on edge N+41
    n0 = t;
    push_now(8'hA5);
    run_until(n0 + 2);
    check("a5_start_low", {31'd0, txd}, 32'd0);
    run_until(n0 + 41);
    check("a5_busy_before_end", {31'd0, busy}, 32'd1);
    run(1);
    check("a5_busy_after_end", {31'd0, busy}, 32'd0);
    check("a5_idle_txd", {31'd0, txd}, 32'd1);
    run(10);

    // Back-to-back 0x00 then 0xFF
    n0 = t;
    src.push_back(8'h00);
    src.push_back(8'hFF);
    run_until(n0 + 42);
    check("b2b_second_start", {31'd0, txd}, 32'd0);
    check("b2b_busy_mid", {31'd0, busy}, 32'd1);
    run_until(n0 + 82);
    check("b2b_busy_end", {31'd0, busy}, 32'd0);
    run(10);

    // Full FIFO: six bytes offered on consecutive cycles
    n0 = t;
    for (int i = 0; i < 6; i++) src.push_back(8'($urandom));
    run_until(n0 + 5);
    check("full_level", {29'd0, fifo_level}, 32'd4);
    check("full_ready", {31'd0, in_ready}, 32'd0);
    run_until(n0 + 42);
    check("full_pop_level", {29'd0, fifo_level}, 32'd3);
    check("full_pop_ready", {31'd0, in_ready}, 32'd1);
    run(1);
    check("full_refill_level", {29'd0, fifo_level}, 32'd4);
    run(6 * FRAME + 10);
    check("full_drained", {31'd0, busy}, 32'd0);

    // Simultaneous push and pop on the final stop edge
    n0 = t;
    src.push_back(8'h5A);
    src.push_back(8'hC3);
    run_until(n0 + 41);
    check("sim_pre_level", {29'd0, fifo_level}, 32'd1);
    push_now(8'h96);
    check("sim_level", {29'd0, fifo_level}, 32'd1);
    check("sim_restart_txd", {31'd0, txd}, 32'd0);
    run(2 * FRAME + 10);

    // Reset during the start bit (txd low before reset)
    n0 = t;
    push_now(8'h3C);
    run_until(n0 + 3);
    check("rst_start_txd_low", {31'd0, txd}, 32'd0);
    do_reset("rst_start");
    run(60);

    // Reset during data bit 3 with another byte queued
    n0 = t;
    src.push_back(8'h3C);
    src.push_back(8'h81);
    run_until(n0 + 19);
    do_reset("rst_bit3");
    run(100);

    // Randomised traffic
    for (int c = 0; c < 2000; c++) begin
      if ((src.size() == 0) && ($urandom_range(0, 24) == 0)) begin
        repeat ($urandom_range(1, 6)) src.push_back(8'($urandom));
      end
      run(1);
    end
    guard = 0;
    while ((src.size() > 0 || active || mq.size() > 0) && guard < 2000) begin
      run(1);
      guard++;
    end
    check("rand_drain_timeout", guard < 2000, 32'd1);
    run(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
